// File: rtl/bht_update_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bht_update_ctrl_pkg
// Brief    : Shared widths, commit-result encoding and counter helper for the
//            BHT update controller.
// Revision : 1.0 - initial release
// ============================================================================
package bht_update_ctrl_pkg;

    localparam int c_depth_def = 16;
    localparam int c_idx_w_def = 8;     // BHT_LR_WIDTH span
    localparam int c_pc_w_def  = 32;
    localparam int c_cnt_w     = 32;

    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = {c_cnt_w{1'b1}};

    typedef enum logic [1:0] {
        CMT_NONE  = 2'd0,
        CMT_RIGHT = 2'd1,
        CMT_WRONG = 2'd2
    } cmt_res_e;

    function automatic logic [c_cnt_w-1:0] sat_inc(input logic [c_cnt_w-1:0] v);
        return (v == c_cnt_max) ? v : v + c_cnt_one;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bht_update_ctrl_br_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bht_update_ctrl_br_fifo
// Brief    : Generic circular FIFO with async reset, flush and push/pop;
//            a push is accepted when full if a pop frees a slot the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module bht_update_ctrl_br_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 41
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     push_ok,
    output logic                     pop_ok
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_head;
    logic [c_aw-1:0]  r_tail;
    logic [c_cw-1:0]  r_count;
    logic [c_cw-1:0]  w_count_nxt;
    logic             w_full;
    logic             w_act;

    assign w_act   = en && !flush;
    assign w_full  = (r_count == c_cw'(DEPTH));
    assign empty   = (r_count == '0);
    assign pop_ok  = w_act && pop && !empty;
    // Full is no obstacle when the same cycle's pop frees the slot.
    assign push_ok = w_act && push && (!w_full || pop_ok);
    assign rd_data = r_mem[r_head];
    assign count   = r_count;

    always_comb begin
        w_count_nxt = r_count;
        if (push_ok && !pop_ok) begin
            w_count_nxt = r_count + c_cw'(1);
        end else if (pop_ok && !push_ok) begin
            w_count_nxt = r_count - c_cw'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (en) begin
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (pop_ok)  r_head <= r_head + c_aw'(1);
                if (push_ok) r_tail <= r_tail + c_aw'(1);
                r_count <= w_count_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            r_mem[r_tail] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bht_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bht_update_ctrl
// Brief    : Records predicted branches in order and, at ROB commit, emits the
//            BHT right/wrong update pulses and the mispredict redirect.
// Revision : 1.0 - initial release
// ============================================================================
module bht_update_ctrl
    import bht_update_ctrl_pkg::*;
#(
    parameter int DEPTH = c_depth_def,
    parameter int IDX_W = c_idx_w_def,
    parameter int PC_W  = c_pc_w_def
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               Clear_flag,
    input  logic               alloc_valid,
    input  logic [IDX_W-1:0]   alloc_bht_id,
    input  logic               alloc_pred,
    input  logic [PC_W-1:0]    alloc_alt_pc,
    output logic               alloc_full,
    input  logic               cmt_valid,
    input  logic               cmt_taken,
    output logic               bht_wrong,
    output logic               bht_right,
    output logic [IDX_W-1:0]   bht_upd_id,
    output logic               mispredict,
    output logic [PC_W-1:0]    redirect_pc,
    output logic [31:0]        cnt_branch,
    output logic [31:0]        cnt_miss,
    output logic               err_flag
);

    localparam int c_ew = IDX_W + 1 + PC_W;
    localparam int c_cw = $clog2(DEPTH) + 1;

    logic [c_ew-1:0]    w_wr_data;
    logic [c_ew-1:0]    w_rd_data;
    logic [c_cw-1:0]    w_count;
    logic               w_empty;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic [IDX_W-1:0]   w_head_id;
    logic               w_head_pred;
    logic [PC_W-1:0]    w_head_alt;
    cmt_res_e           w_cmt_res;
    logic               w_overflow;
    logic               w_underflow;

    logic               r_bht_wrong;
    logic               r_bht_right;
    logic               r_mispredict;
    logic [IDX_W-1:0]   r_bht_upd_id;
    logic [PC_W-1:0]    r_redirect_pc;
    logic [31:0]        r_cnt_branch;
    logic [31:0]        r_cnt_miss;
    logic               r_err_flag;

    assign w_wr_data = {alloc_bht_id, alloc_pred, alloc_alt_pc};

    bht_update_ctrl_br_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ew)
    ) u_br_fifo (
        .clk     (clk),
        .rst     (rst),
        .en      (rdy),
        .flush   (Clear_flag),
        .push    (alloc_valid),
        .pop     (cmt_valid),
        .wr_data (w_wr_data),
        .rd_data (w_rd_data),
        .count   (w_count),
        .empty   (w_empty),
        .push_ok (w_push_ok),
        .pop_ok  (w_pop_ok)
    );

    assign w_head_id   = w_rd_data[c_ew-1 -: IDX_W];
    assign w_head_pred = w_rd_data[PC_W];
    assign w_head_alt  = w_rd_data[PC_W-1:0];

    always_comb begin
        w_cmt_res = CMT_NONE;
        if (w_pop_ok) begin
            w_cmt_res = (cmt_taken != w_head_pred) ? CMT_WRONG : CMT_RIGHT;
        end
    end

    // Only meaningful in the normal branch below, where the FIFO is enabled.
    assign w_overflow  = alloc_valid && !w_push_ok;
    assign w_underflow = cmt_valid && w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bht_wrong   <= 1'b0;
            r_bht_right   <= 1'b0;
            r_mispredict  <= 1'b0;
            r_bht_upd_id  <= '0;
            r_redirect_pc <= '0;
            r_cnt_branch  <= '0;
            r_cnt_miss    <= '0;
            r_err_flag    <= 1'b0;
        end else if (!rdy || Clear_flag) begin
            r_bht_wrong   <= 1'b0;
            r_bht_right   <= 1'b0;
            r_mispredict  <= 1'b0;
        end else begin
            r_bht_wrong   <= (w_cmt_res == CMT_WRONG);
            r_bht_right   <= (w_cmt_res == CMT_RIGHT);
            r_mispredict  <= (w_cmt_res == CMT_WRONG);
            if (w_cmt_res != CMT_NONE) begin
                r_bht_upd_id <= w_head_id;
                r_cnt_branch <= sat_inc(r_cnt_branch);
            end
            if (w_cmt_res == CMT_WRONG) begin
                r_redirect_pc <= w_head_alt;
                r_cnt_miss    <= sat_inc(r_cnt_miss);
            end
            if (w_overflow || w_underflow) begin
                r_err_flag <= 1'b1;
            end
        end
    end

    assign alloc_full  = (w_count == c_cw'(DEPTH));
    assign bht_wrong   = r_bht_wrong;
    assign bht_right   = r_bht_right;
    assign mispredict  = r_mispredict;
    assign bht_upd_id  = r_bht_upd_id;
    assign redirect_pc = r_redirect_pc;
    assign cnt_branch  = r_cnt_branch;
    assign cnt_miss    = r_cnt_miss;
    assign err_flag    = r_err_flag;

endmodule
`default_nettype wire
